// File: rtl/ela_pkg.sv
// Shared definitions for the ELA frame readback path: geometry defaults,
// reader FSM encoding and the pixel entry carried through the output FIFO.
package ela_pkg;

    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  eol;
        logic                  eof;
    } pix_t;

endpackage

// File: rtl/ela_rd_fifo2.sv
// Two-entry FIFO of tagged pixels feeding the frame reader's output port.
// Producer must never push into a full FIFO without a simultaneous pop.
module ela_rd_fifo2
    import ela_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pix_t       push_entry,
    input  logic       pop,
    output pix_t       head,
    output logic [1:0] count
);

    pix_t slots [2];
    logic wr_ptr;
    logic rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slots[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/ela_frame_reader.sv
// Reads the finished deinterlaced frame back in raster order and streams it
// out with row/frame markers. Optional checksum port: ELA_RD_CHECKSUM_EN.
module ela_frame_reader
    import ela_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done
`ifdef ELA_RD_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Tags of the read currently on the bus, then of the one whose data is returning.
    logic ren_eol, ren_eof;
    logic pend_valid, pend_eol, pend_eof;

    pix_t       skid;
    logic       skid_valid;
    pix_t       head;
    pix_t       push_entry;
    logic [1:0] fifo_count;
    logic [2:0] occupancy;
    logic       push, pop, room, credit_ok, issue, last_col, last_row;

    // A read already on the bus when the consumer stalls lands in the skid slot,
    // so counting only that read as in flight keeps full rate without loss.
    always_comb begin
        last_col   = (col == COL_W'(IMG_W - 1));
        last_row   = (row == ROW_W'(IMG_H - 1));
        pop        = out_valid & out_ready;
        room       = (fifo_count < 2'd2) | pop;
        push       = (skid_valid | pend_valid) & room;
        push_entry = skid_valid ? skid : pix_t'{data: mem_rdata, eol: pend_eol, eof: pend_eof};
        occupancy  = 3'(fifo_count) + 3'(skid_valid) + 3'(mem_ren) - 3'(pop);
        credit_ok  = (occupancy < 3'd2);
        issue      = (((state == S_IDLE) || (state == S_DONE)) && start)
                   || ((state == S_READ) && credit_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mem_ren    <= 1'b0;
            mem_addr   <= '0;
            col        <= '0;
            row        <= '0;
            ren_eol    <= 1'b0;
            ren_eof    <= 1'b0;
            pend_valid <= 1'b0;
            pend_eol   <= 1'b0;
            pend_eof   <= 1'b0;
            skid       <= '0;
            skid_valid <= 1'b0;
`ifdef ELA_RD_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            mem_ren    <= issue;
            pend_valid <= mem_ren;
            pend_eol   <= ren_eol;
            pend_eof   <= ren_eof;

            if (issue) begin
                mem_addr <= ADDR_W'({row, col});
                ren_eol  <= last_col;
                ren_eof  <= last_col & last_row;
                col      <= last_col ? '0 : col + 1'b1;
                if (last_col) begin
                    row <= last_row ? '0 : row + 1'b1;
                end
            end

            if (skid_valid & room) begin
                skid_valid <= 1'b0;
            end else if (pend_valid & ~room) begin
                skid       <= push_entry;
                skid_valid <= 1'b1;
            end

`ifdef ELA_RD_CHECKSUM_EN
            if (pop) begin
                checksum <= checksum + 16'(head.data);
            end
`endif

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_READ;
                        busy       <= 1'b1;
                        frame_done <= 1'b0;
`ifdef ELA_RD_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (issue && last_col && last_row) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && head.eof) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ela_rd_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head.data;
    assign out_eol   = head.eol;
    assign out_eof   = head.eof;

endmodule

// File: tb/tb_ela_frame_reader.sv
// Directed bench for ela_frame_reader: reset, full frames, backpressure,
// ignored start pulses and mid-frame reset against a pixel=addr[7:0] memory.
module tb_ela_frame_reader;
    import ela_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_ren;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_eol;
    logic       out_eof;
    logic       busy;
    logic       frame_done;
`ifdef ELA_RD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    ela_frame_reader #(
        .IMG_W (32),
        .IMG_H (32),
        .ADDR_W(10),
        .DATA_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef ELA_RD_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? mem_addr[7:0] : 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, 32'({out_valid, out_eol, out_eof, out_data, busy, frame_done, mem_ren, mem_addr}), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(S_IDLE));
`ifdef ELA_RD_CHECKSUM_EN
        check({tag, "_csum"}, 32'(checksum), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One readout. Cycle 0 is the cycle carrying the start pulse.
    task automatic run_frame(input int drop_at, input bit extra_start, input int abort_at, input bit timed);
        int   cyc         = 0;
        int   beat        = 0;
        int   next_addr   = 0;
        int   first_valid = -1;
        int   eof_cyc     = -1;
        int   stall_left  = 0;
        bit   dropped     = 0;
        bit   mid_started = 0;
        bit   drn_started = 0;
        bit   done_seen   = 0;
        bit   aborted     = 0;
        bit   stalled     = 0;
        logic [10:0] held = '0;
        logic [9:0]  exp_beat;
        while (cyc < 3000 && !done_seen && !aborted) begin
            start = (cyc == 0);
            if (extra_start && !mid_started && beat == 500) begin
                start = 1'b1;
                mid_started = 1;
            end
            if (extra_start && !drn_started && next_addr == 1024) begin
                start = 1'b1;
                drn_started = 1;
            end
            if (drop_at >= 0 && !dropped && beat == drop_at) begin
                dropped = 1;
                stall_left = 10;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;

            if (mem_ren) begin
                check("rd_addr", 32'(mem_addr), 32'(next_addr));
                next_addr++;
            end
            if (stalled) begin
                check("hold", 32'({out_valid, out_eof, out_eol, out_data}), 32'(held));
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, out_eof, out_eol, out_data};
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                exp_beat = {(beat == 1023), (beat % 32 == 31), beat[7:0]};
                check("beat", 32'({out_eof, out_eol, out_data}), 32'(exp_beat));
                if (out_eof) eof_cyc = cyc;
                beat++;
                if (abort_at >= 0 && beat == abort_at) aborted = 1;
            end
            if (cyc > 0 && frame_done) begin
                done_seen = 1;
                check("done_cycle", 32'(cyc), 32'(eof_cyc + 1));
                check("busy_at_done", 32'(busy), 32'd0);
            end
            if (!done_seen && !aborted) begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check("beats", 32'(beat), 32'd1024);
            check("done_seen", 32'(done_seen), 32'd1);
            if (timed) begin
                check("first_valid", 32'(first_valid), 32'd3);
                check("eof_cycle", 32'(eof_cyc), 32'd1026);
            end
`ifdef ELA_RD_CHECKSUM_EN
            check("checksum", 32'(checksum), 32'h0000FE00);
`endif
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            check_idle("reset_hold");
        end
        rst = 1'b0;
        repeat (5) begin
            tick();
            check_idle("idle_after_reset");
        end

        out_ready = 1'b1;
        run_frame(-1, 1'b0, -1, 1'b1);
        check("busy_idle_done", 32'({busy, frame_done}), 32'b01);

        run_frame(100, 1'b0, -1, 1'b0);
        run_frame(-1, 1'b1, -1, 1'b1);

        run_frame(-1, 1'b0, 300, 1'b0);
        rst = 1'b1;
        repeat (2) begin
            tick();
            check_idle("mid_reset");
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            check_idle("post_abort_idle");
        end
        run_frame(-1, 1'b0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ela_frame_reader.md
Name: ela_frame_reader

Overview:
Downstream stage of the ELA deinterlacer. Once the deinterlacer finishes, this block reads the completed 32x32 frame back from the shared result memory in raster order. It streams the pixels out over a valid/ready interface with row and frame markers. The top-level memory-port mux gives this block the port while its busy output is high.

Parameters:
IMG_W, 32, pixels per row (power of two)
IMG_H, 32, rows per frame
ADDR_W, 10, memory address width; address = row*IMG_W + col
DATA_W, 8, pixel width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse from deinterlacer done rising edge
mem_ren  out  1  memory read strobe (registered)
mem_addr  out  ADDR_W  memory read address (registered)
mem_rdata  in  DATA_W  read data, valid the cycle after mem_ren=1
out_valid  out  1  pixel available
out_ready  in  1  consumer accepts pixel
out_data  out  DATA_W  pixel value
out_eol  out  1  pixel is last of its row (col==IMG_W-1)
out_eof  out  1  pixel is last of frame
busy  out  1  frame readout in progress
frame_done  out  1  level, frame fully delivered

Interface:
- Reset rst is synchronous and active-high; clock is clk.

Behaviour:
- Reset values: every output is 0. The FSM is in IDLE, the counters are 0 and the FIFO is empty.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ when start=1. In the following cycle busy=1 and the first read is issued (mem_ren=1, mem_addr=0).
- READ: one read per cycle while credit allows. After each issue the column counter increments; at IMG_W-1 it wraps to 0 and the row counter increments.
- READ -> DRAIN in the cycle the last address (IMG_H*IMG_W-1) is issued.
- DRAIN -> DONE on the handshake (out_valid & out_ready) of the out_eof pixel. In DONE, busy=0 and frame_done=1.
- DONE -> READ on start=1. This clears frame_done and restarts at address 0.
- start in READ or DRAIN is ignored.
- Read latency: mem_rdata for a read issued in cycle T is captured into the 2-entry output FIFO at the end of cycle T+1. out_valid rises in cycle T+2.
- Credit rule: issue only when (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready in the current cycle. This sustains 1 pixel/cycle with out_ready held high and never overflows the FIFO.
- out_data, out_eol and out_eof come from the FIFO head. The row/col tags are carried through the FIFO alongside the data.
- out_valid, once high, stays high with stable data and tags until accepted.
- mem_ren=0 whenever not issuing. mem_addr holds its last value when not issuing.
- Reset mid-frame: the block returns to IDLE immediately. The FIFO is flushed, and any outstanding read data is discarded, never presented.

Optional Feature:
- Macro: ELA_RD_CHECKSUM_EN.
- With the macro defined:
  - Adds output checksum[15:0], reset to 0.
  - Holds a running modulo-2^16 sum of every accepted pixel, zero-extended.
  - Cleared when a new readout starts (the IDLE->READ or DONE->READ transition).
  - Holds its final value in DONE.
- Without the macro: no checksum port and no accumulator logic.

Decomposition:
- Shared package ela_pkg holds:
  - IMG_W, IMG_H, ADDR_W, DATA_W defaults
  - the FSM state encoding typedef
  - a pixel-tag struct (data, eol, eof)
- One sub-module: ela_rd_fifo2, a 2-entry FIFO of pixel-tag entries with push, pop, count, and head outputs.

Test Plan:
- Reset: assert rst for 3 cycles. Every output is 0 and the FSM is in IDLE, both during reset and for 5 idle cycles after.
- Full frame, out_ready=1, memory holds pixel=addr[7:0]:
  - start pulsed in cycle 0.
  - First out_valid in cycle 3 with data 0x00.
  - 1024 consecutive beats; out_eol on every 32nd beat.
  - out_eof in cycle 1026 with data 0xFF.
  - frame_done=1 and busy=0 from cycle 1027.
- Backpressure: drop out_ready for 10 cycles at pixel 100. No more than 2 reads are outstanding, no pixel is lost or duplicated, and the stream resumes with pixel 100 held stable.
- start pulsed at pixel 500 in READ and again in DRAIN: both are ignored, and the output sequence and count (1024) are unchanged.
- Reset at pixel 300, then start: readout restarts at address 0, with no stale pixel emitted.
- With ELA_RD_CHECKSUM_EN defined and the full-frame pattern above: checksum=16'hFE00 at frame_done. A second frame yields 16'hFE00 again, confirming the accumulator clears.
